uart_tx_arbiter: RTL

// - Shares one UART transmitter between NUM_REQ byte producers (e.g. echo path, status reporter, debug dump).
// - Picks one pending requester by round-robin, latches its byte, pulses tx_start and tracks tx_busy until the frame ends.
// - Sits between the requesters and the transmitter, in the baud_clk domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_rr_pick.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART package: FSM state codes used by the receiver, transmitter and
// transmit arbiter, plus the byte width.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE      = 2'd0;
   localparam state_t START     = 2'd1;
   localparam state_t WAIT_BUSY = 2'd2;
   localparam state_t WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side bundle of the UART transmit arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
) ();

   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*BYTE_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [BYTE_W-1:0]         tx_data;
   logic                      tx_start;
   logic                      tx_busy;
   logic [IDW-1:0]            grant_id;
   logic                      arb_busy;
   logic                      timeout_err;

   modport master (
      input  req, req_data, tx_busy,
      output ack, tx_data, tx_start, grant_id, arb_busy, timeout_err
   );

   modport slave (
      output req, req_data, tx_busy,
      input  ack, tx_data, tx_start, grant_id, arb_busy, timeout_err
   );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational winner select for the UART transmit arbiter.
// Build option UART_ARB_FIXED_PRIORITY_EN: lowest pending index wins instead of round-robin.
module uart_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     last_grant_i,
   output logic [IDW-1:0]     winner_o,
   output logic               valid_o
);

`ifdef UART_ARB_FIXED_PRIORITY_EN
   logic unused_last;
   assign unused_last = ^last_grant_i;

   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            winner_o = IDW'(i);
            valid_o  = 1'b1;
         end
      end
   end
`else
   // Scan offsets from farthest to nearest so the nearest pending requester
   // after last_grant overwrites the rest; offset NUM_REQ is last_grant itself.
   always_comb begin
      int idx;
      idx      = 0;
      winner_o = '0;
      valid_o  = 1'b0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = int'(last_grant_i) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_i[idx[IDW-1:0]]) begin
            winner_o = idx[IDW-1:0];
            valid_o  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers in the baud_clk domain.
// Build option UART_ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic               baud_clk,
   input  logic               reset,
   uart_tx_arbiter_if.master  bus
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(BUSY_TIMEOUT);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IDW-1:0]      last_q, last_d;
   logic [IDW-1:0]      gid_q, gid_d;
   logic [BYTE_W-1:0]   txd_q, txd_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;

   logic [IDW-1:0]      win;
   logic                win_vld;
   logic                tx_start;
   logic                arb_busy;
   logic                timeout_err;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i        (bus.req),
      .last_grant_i (last_q),
      .winner_o     (win),
      .valid_o      (win_vld)
   );

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= IDW'(NUM_REQ - 1);
         gid_q   <= '0;
         txd_q   <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         txd_q   <= txd_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gid_d   = gid_q;
      txd_d   = txd_q;
      ack_d   = '0;
      case (state_q)
         IDLE: begin
            if (win_vld && !bus.tx_busy) begin
               ack_d[win] = 1'b1;
               txd_d      = bus.req_data[int'(win)*BYTE_W +: BYTE_W];
               gid_d      = win;
               last_d     = win;
               state_d    = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A frame that never starts is dropped, not retried.
            if (bus.tx_busy)                          state_d = WAIT_DONE;
            else if (cnt_q == CW'(BUSY_TIMEOUT - 1))  state_d = IDLE;
            else                                      cnt_d   = cnt_q + 1'b1;
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_start    = (state_q == START);
      arb_busy    = (state_q != IDLE);
      timeout_err = (state_q == WAIT_BUSY) && !bus.tx_busy &&
                    (cnt_q == CW'(BUSY_TIMEOUT - 1));
   end

   assign bus.ack         = ack_q;
   assign bus.tx_data     = txd_q;
   assign bus.grant_id    = gid_q;
   assign bus.tx_start    = tx_start;
   assign bus.arb_busy    = arb_busy;
   assign bus.timeout_err = timeout_err;

endmodule
